// File: rtl/dec_str_scheduler_if.sv
// Handshake and display-bus bundle between value producers, the shared converter
// and the display text buffer, as seen by dec_str_scheduler.
interface dec_str_scheduler_if #(
   parameter int NCH    = 4,
   parameter int ADDR_W = 8
);
   logic [NCH-1:0]    req_valid;
   logic [5*NCH-1:0]  req_val;
   logic [NCH-1:0]    req_ready;
   logic signed [4:0] conv_n;
   logic [23:0]       conv_str;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic              busy;
   logic              range_err;
   logic              clr_err;

   // master: producers, converter and buffer side; slave: the scheduler
   modport master (
      output req_valid, req_val, conv_str, clr_err,
      input  req_ready, conv_n, wr_en, wr_addr, wr_data, busy, range_err
   );
   modport slave (
      input  req_valid, req_val, conv_str, clr_err,
      output req_ready, conv_n, wr_en, wr_addr, wr_data, busy, range_err
   );
endinterface

// File: rtl/dec_str_scheduler.sv
// Round-robin time-sharing of one signed-digit-to-ASCII converter between NCH display
// fields; each converted string is written to its 3-byte slot in the display buffer.
module dec_str_scheduler #(
   parameter int NCH       = 4,
   parameter int CONV_LAT  = 2,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   dec_str_scheduler_if.slave bus
);
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

   state_t            state, state_nxt;
   logic [NCH-1:0]    pending;
   logic signed [4:0] hold [NCH];
   logic [CH_W-1:0]   ch, last_grant, grant;
   logic              grant_vld;
   logic [CNT_W-1:0]  cnt;
   logic              do_grant, do_write;
   logic [NCH-1:0]    acc, grant_mask;

   logic signed [4:0] conv_n;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic              range_err;

   function automatic logic out_of_range(input logic signed [4:0] v);
      return (v > 5'sd9) || (v < -5'sd9);
   endfunction

   assign acc           = bus.req_valid & ~pending;
   assign bus.req_ready = ~pending;
   assign bus.conv_n    = conv_n;
   assign bus.wr_en     = wr_en;
   assign bus.wr_addr   = wr_addr;
   assign bus.wr_data   = wr_data;
   assign bus.busy      = (state != IDLE);
   assign bus.range_err = range_err;

   // Search starts one past the last granted channel so every field gets a fair turn
   always_comb begin
      int idx;
      idx       = 0;
      grant     = last_grant;
      grant_vld = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         idx = (int'(last_grant) + i) % NCH;
         if (!grant_vld && pending[idx]) begin
            grant     = CH_W'(idx);
            grant_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_write  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = WAIT;
               do_grant  = 1'b1;
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(CONV_LAT - 1)) state_nxt = WRITE;
         end
         WRITE: begin
            state_nxt = IDLE;
            do_write  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign grant_mask = do_grant ? (NCH'(1) << grant) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         last_grant <= CH_W'(NCH - 1);
         ch         <= '0;
         cnt        <= '0;
         conv_n     <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         range_err  <= 1'b0;
         for (int k = 0; k < NCH; k++) hold[k] <= '0;
      end else begin
         state   <= state_nxt;
         // accept only targets non-pending channels and grant only pending ones, so no overlap
         pending <= (pending | acc) & ~grant_mask;
         for (int k = 0; k < NCH; k++) begin
            if (acc[k]) hold[k] <= $signed(bus.req_val[5*k +: 5]);
         end
         wr_en <= do_write;
         if (do_grant) begin
            conv_n     <= hold[grant];
            ch         <= grant;
            last_grant <= grant;
            cnt        <= '0;
         end else if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (do_write) begin
            wr_data <= bus.conv_str;
            wr_addr <= ADDR_W'(BASE_ADDR + 3 * int'(ch));
         end
         if (do_write && out_of_range(conv_n)) range_err <= 1'b1;
         else if (bus.clr_err)                  range_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dec_str_scheduler.sv
// Scoreboard bench for dec_str_scheduler: a two-stage converter model feeds conv_str,
// expected buffer writes are queued at stimulus time and popped as wr_en pulses appear.
module tb_dec_str_scheduler;
   localparam int NCH    = 4;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [31:0] exp_q [$];
   int          wr_cyc [$];
   logic [31:0] mon_e;
   logic [23:0] conv_s1 = '0;
   logic [23:0] conv_s2 = '0;

   dec_str_scheduler_if #(.NCH(NCH), .ADDR_W(ADDR_W)) bus ();

   dec_str_scheduler #(.NCH(NCH), .CONV_LAT(2), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] conv_f(input logic signed [4:0] v);
      logic [5:0] a;
      logic [7:0] s;
      logic [7:0] d;
      s = (v < 0) ? 8'h2D : 8'h2B;
      a = (v < 0) ? 6'(-int'(v)) : 6'(int'(v));
      d = (a <= 6'd9) ? 8'h30 + 8'(a) : 8'h3F;
      return {s, 8'h20, d};
   endfunction

   // Converter model: two registered stages
   always @(posedge clk) begin
      conv_s1 <= conv_f(bus.conv_n);
      conv_s2 <= conv_s1;
   end
   assign bus.conv_str = conv_s2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.wr_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wr", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", {24'd0, bus.wr_addr}, {24'd0, mon_e[31:24]});
            chk("wr_data", {8'd0, bus.wr_data}, {8'd0, mon_e[23:0]});
         end
         wr_cyc.push_back(cyc);
      end
   end

   function automatic logic [31:0] exp_of(input int k, input logic signed [4:0] v);
      return {8'(3 * k), conv_f(v)};
   endfunction

   task automatic set_val(input int k, input logic signed [4:0] v);
      bus.req_val[5*k +: 5] = v;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, exp_q.size() == 0}, 32'd1);
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_conv_n"},  {27'd0, bus.conv_n}, 32'd0);
      chk({tag, "_wr_en"},   {31'd0, bus.wr_en}, 32'd0);
      chk({tag, "_wr_addr"}, {24'd0, bus.wr_addr}, 32'd0);
      chk({tag, "_wr_data"}, {8'd0, bus.wr_data}, 32'd0);
      chk({tag, "_busy"},    {31'd0, bus.busy}, 32'd0);
      chk({tag, "_rerr"},    {31'd0, bus.range_err}, 32'd0);
      chk({tag, "_ready"},   {28'd0, bus.req_ready}, 32'hF);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_val   = '0;
      bus.clr_err   = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("rst");
      rst_n = 1'b1;

      // Reset in the middle of a conversion abandons it
      @(negedge clk);
      bus.req_valid[0] = 1'b1;
      set_val(0, 5'sd5);
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      chk("t1_busy", {31'd0, bus.busy}, 32'd1);
      chk("t1_conv_n", {27'd0, bus.conv_n}, 32'd5);
      #2 rst_n = 1'b0;
      #1 chk_idle_outputs("t1_async");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("t1_ready_after", {28'd0, bus.req_ready}, 32'hF);
      chk("t1_busy_after", {31'd0, bus.busy}, 32'd0);

      // Single conversion: latency and one-cycle strobe
      @(negedge clk);
      bus.req_valid[2] = 1'b1;
      set_val(2, -5'sd7);
      exp_q.push_back({8'd6, 24'h2D2037});
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      chk("t2_busy", {31'd0, bus.busy}, 32'd1);
      chk("t2_wr_early1", {31'd0, bus.wr_en}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("t2_wr_early", {31'd0, bus.wr_en}, 32'd0);
      end
      @(negedge clk);
      chk("t2_wr_lat", {31'd0, bus.wr_en}, 32'd1);
      @(negedge clk);
      chk("t2_wr_once", {31'd0, bus.wr_en}, 32'd0);
      chk("t2_rerr", {31'd0, bus.range_err}, 32'd0);
      drain("t2_drain");

      // Round-robin burst with ch1 requeued right after its grant
      do_reset();
      wr_cyc.delete();
      @(negedge clk);
      bus.req_valid = 4'hF;
      set_val(0, 5'sd3);
      set_val(1, -5'sd1);
      set_val(2, 5'sd0);
      set_val(3, 5'sd9);
      exp_q.push_back(exp_of(0, 5'sd3));
      exp_q.push_back(exp_of(1, -5'sd1));
      exp_q.push_back(exp_of(2, 5'sd0));
      exp_q.push_back(exp_of(3, 5'sd9));
      @(negedge clk);
      bus.req_valid = '0;
      repeat (4) @(negedge clk);
      chk("t4_ready_pend", {31'd0, bus.req_ready[1]}, 32'd0);
      @(negedge clk);
      chk("t4_ready_back", {31'd0, bus.req_ready[1]}, 32'd1);
      bus.req_valid[1] = 1'b1;
      set_val(1, 5'sd5);
      exp_q.push_back(exp_of(1, 5'sd5));
      @(negedge clk);
      bus.req_valid = '0;
      chk("t4_accepted", {31'd0, bus.req_ready[1]}, 32'd0);
      drain("t3_drain");
      chk("t3_nwr", wr_cyc.size(), 32'd5);
      if (wr_cyc.size() == 5) begin
         for (int i = 1; i < 5; i++) chk("t3_spacing", wr_cyc[i] - wr_cyc[i-1], 32'd4);
      end
      chk("t3_rerr", {31'd0, bus.range_err}, 32'd0);

      // Range error: set, clear, and set winning over a coincident clear
      @(negedge clk);
      bus.req_valid[0] = 1'b1;
      set_val(0, -5'sd16);
      exp_q.push_back(exp_of(0, -5'sd16));
      @(negedge clk);
      bus.req_valid = '0;
      drain("t5_drain_a");
      chk("t5_rerr_set", {31'd0, bus.range_err}, 32'd1);
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      chk("t5_rerr_clr", {31'd0, bus.range_err}, 32'd0);
      @(negedge clk);
      bus.req_valid[1] = 1'b1;
      set_val(1, 5'sd12);
      exp_q.push_back(exp_of(1, 5'sd12));
      @(negedge clk);
      bus.req_valid = '0;
      repeat (3) @(negedge clk);
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      chk("t5_wr_coinc", {31'd0, bus.wr_en}, 32'd1);
      chk("t5_set_wins", {31'd0, bus.range_err}, 32'd1);
      drain("t5_drain_b");
      chk("t5_sticky", {31'd0, bus.range_err}, 32'd1);
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      chk("t5_rerr_clr2", {31'd0, bus.range_err}, 32'd0);

      // Backpressure: ch0 waits behind ch2 while its valid stays high with a new value
      @(negedge clk);
      bus.req_valid = 4'b0101;
      set_val(2, -5'sd9);
      set_val(0, 5'sd4);
      exp_q.push_back(exp_of(2, -5'sd9));
      exp_q.push_back(exp_of(0, 5'sd4));
      @(negedge clk);
      bus.req_valid[2] = 1'b0;
      set_val(0, 5'sd7);
      repeat (3) begin
         chk("t6_ready0", {31'd0, bus.req_ready[0]}, 32'd0);
         @(negedge clk);
      end
      bus.req_valid = '0;
      drain("t6_drain");
      chk("t6_rerr", {31'd0, bus.range_err}, 32'd0);
      chk("t6_ready_end", {28'd0, bus.req_ready}, 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
